stream_parity_unit: RTL and testbench

Parametrised, frame-based parity generator/checker. It accepts a stream of DATA_W-bit beats over a valid/ready handshake and folds every beat of a frame into one parity bit, using even or odd parity. In generate mode it emits the frame parity; in check mode it compares that parity against a supplied parity bit and flags a mismatch. It sits between a data source and a framing/link block, and keeps a saturating error counter for status reporting.

---
 rtl/stream_parity_pkg.sv | 30 +++
 rtl/stream_parity_unit_reduce.sv | 20 ++
 rtl/stream_parity_unit.sv | 137 +++++++++++++
 tb/tb_stream_parity_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_parity_pkg
// Description : Shared types and helpers for the frame parity generator/checker.
// Revision    : 1.0 - initial release
// ============================================================================
package stream_parity_pkg;

    // Frame operating mode, captured on the first beat of each frame
    typedef enum logic {
        PAR_GEN = 1'b0,
        PAR_CHK = 1'b1
    } par_mode_t;

    localparam int c_state_w = 2;

    // Frame-level control states
    typedef enum logic [c_state_w-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_RESULT = 2'd2
    } par_state_t;

    // Turns an even-parity fold into the configured sense (odd = inverted)
    function automatic logic apply_sense(input logic even_par, input logic odd_sel);
        return even_par ^ odd_sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_parity_unit_reduce.sv
`default_nettype none
// ============================================================================
// Module      : parity_reduce
// Description : Combinational XOR reduction of a W-bit word to one parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_reduce #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_data,
    output logic         o_parity
);

    // Even parity of the word; synthesis builds the balanced XOR tree
    always_comb begin
        o_parity = ^i_data;
    end

endmodule
`default_nettype wire

// File: rtl/stream_parity_unit.sv
`default_nettype none
// ============================================================================
// Module      : stream_parity_unit
// Description : Frame-based parity generator/checker on a valid/ready stream
//               with a saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_parity_unit
    import stream_parity_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ODD    = 0,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count,
    output logic              busy
);

    localparam logic             c_odd_sel = (ODD != 0);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    par_state_t       r_state;
    par_state_t       w_state_next;
    logic             r_acc;
    par_mode_t        r_mode_q;
    logic             r_out_parity;
    logic             r_out_err;
    logic [CNT_W-1:0] r_err_count;

    logic w_beat_par;
    logic w_accept;
    logic w_first;
    logic w_fold;
    logic w_frame_par;
    logic w_mode_eff;
    logic w_result_take;

    parity_reduce #(
        .W(DATA_W)
    ) u_reduce (
        .i_data  (in_data),
        .o_parity(w_beat_par)
    );

    // Handshake and fold terms; a beat taken while a result drains opens a new frame
    always_comb begin
        in_ready      = ~out_valid | out_ready;
        w_accept      = in_valid & in_ready;
        w_result_take = out_valid & out_ready;
        w_first       = (r_state != ST_ACCUM);
        w_fold        = w_first ? w_beat_par : (r_acc ^ w_beat_par);
        w_frame_par   = apply_sense(w_fold, c_odd_sel);
        w_mode_eff    = w_first ? (mode == PAR_CHK) : (r_mode_q == PAR_CHK);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESULT: begin
                if (w_accept) begin
                    w_state_next = in_last ? ST_RESULT : ST_ACCUM;
                end else if ((r_state == ST_RESULT) && out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (w_accept && in_last) begin
                    w_state_next = ST_RESULT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and registered result fields
    always_comb begin
        out_valid  = (r_state == ST_RESULT);
        busy       = (r_state == ST_ACCUM);
        out_parity = r_out_parity;
        out_err    = r_out_err;
        err_count  = r_err_count;
    end

    // Accumulator, captured mode and frame result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= 1'b0;
            r_mode_q     <= PAR_GEN;
            r_out_parity <= 1'b0;
            r_out_err    <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_acc        <= 1'b0;
                r_out_parity <= w_frame_par;
                r_out_err    <= w_mode_eff & (w_frame_par != in_par);
            end else begin
                r_acc <= w_fold;
                if (w_first) begin
                    r_mode_q <= par_mode_t'(mode);
                end
            end
        end
    end

    // Saturating count of delivered results that carried an error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_result_take && r_out_err && (r_err_count != c_cnt_max)) begin
            r_err_count <= r_err_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_parity_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_parity_unit
// Description : Self-checking bench; two instances (even/CNT_W=8 and
//               odd/CNT_W=2) share stimulus and are compared to a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_parity_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_par;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_parity0, out_err0, busy0;
    logic [7:0] err_count0;
    logic       in_ready1, out_valid1, out_parity1, out_err1, busy1;
    logic [1:0] err_count1;

    int n_checks = 0;
    int n_err    = 0;

    // Frame-level reference model
    bit          m_valid, m_open, m_mode, m_last_acc;
    int unsigned m_ones;
    bit          m_par [2];
    bit          m_err [2];
    int          m_cnt [2];
    int          c_sat [2] = '{255, 3};

    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       l;
        bit       m;
        bit       p;
        bit       r;
        bit       e_v;
        bit       e_p0;
        bit       e_p1;
        bit       e_e0;
        int       e_c0;
    } vec_t;

    vec_t tbl [15];
    int   sat_exp [5] = '{1, 2, 3, 3, 3};

    always #5 clk = ~clk;

    stream_parity_unit #(.DATA_W(8), .ODD(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(out_valid0),
        .out_ready(out_ready), .out_parity(out_parity0), .out_err(out_err0),
        .err_count(err_count0), .busy(busy0)
    );

    stream_parity_unit #(.DATA_W(8), .ODD(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .out_valid(out_valid1),
        .out_ready(out_ready), .out_parity(out_parity1), .out_err(out_err1),
        .err_count(err_count1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: update the model from pre-edge inputs, then compare after the edge
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy = !m_valid || out_ready;
        if (rst) begin
            m_valid = 0; m_open = 0; m_last_acc = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            chk("in_ready0", in_ready0, exp_rdy);
            chk("in_ready1", in_ready1, exp_rdy);
            m_last_acc = in_valid && exp_rdy;
            if (m_valid && out_ready) begin
                for (int k = 0; k < 2; k++)
                    if (m_err[k] && m_cnt[k] < c_sat[k]) m_cnt[k]++;
                m_valid = 0;
            end
            if (m_last_acc) begin
                if (!m_open) begin
                    m_ones = 0;
                    m_mode = mode;
                end
                m_ones += $countones(in_data);
                if (in_last) begin
                    for (int k = 0; k < 2; k++) begin
                        m_par[k] = ((m_ones % 2) == 1) ^ (k == 1);
                        m_err[k] = m_mode && (m_par[k] != in_par);
                    end
                    m_valid = 1;
                    m_open  = 0;
                end else begin
                    m_open = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid0", out_valid0, m_valid);
        chk("out_valid1", out_valid1, m_valid);
        chk("busy0", busy0, m_open);
        chk("busy1", busy1, m_open);
        chk("err_count0", err_count0, m_cnt[0]);
        chk("err_count1", err_count1, m_cnt[1]);
        if (m_valid) begin
            chk("out_parity0", out_parity0, m_par[0]);
            chk("out_parity1", out_parity1, m_par[1]);
            chk("out_err0", out_err0, m_err[0]);
            chk("out_err1", out_err1, m_err[1]);
        end
    endtask

    task automatic drive(input bit v, input bit [7:0] d, input bit l,
                         input bit m, input bit p, input bit r);
        in_valid = v; in_data = d; in_last = l; mode = m; in_par = p; out_ready = r;
    endtask

    initial begin
        //             v  data   l  m  p  r   e_v p0 p1 e0 c0
        tbl[0]  = '{1, 8'hA5, 1, 0, 0, 1,  1, 0, 1, 0, 0};
        tbl[1]  = '{1, 8'h01, 0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[2]  = '{1, 8'h03, 0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[3]  = '{1, 8'h07, 1, 0, 0, 1,  1, 0, 1, 0, 0};
        tbl[4]  = '{1, 8'hFF, 0, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[5]  = '{1, 8'h01, 1, 0, 0, 1,  1, 1, 0, 1, 0};
        tbl[6]  = '{0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 1};
        tbl[7]  = '{1, 8'hFF, 0, 1, 0, 1,  0, 0, 0, 0, 1};
        tbl[8]  = '{1, 8'h01, 1, 0, 1, 1,  1, 1, 0, 0, 1};
        tbl[9]  = '{0, 8'h00, 0, 0, 0, 0,  1, 1, 0, 0, 1};
        tbl[10] = '{1, 8'h33, 1, 0, 0, 0,  1, 1, 0, 0, 1};
        tbl[11] = '{1, 8'h33, 1, 0, 0, 0,  1, 1, 0, 0, 1};
        tbl[12] = '{1, 8'h33, 1, 0, 0, 0,  1, 1, 0, 0, 1};
        tbl[13] = '{1, 8'h33, 1, 0, 0, 1,  1, 0, 1, 0, 1};
        tbl[14] = '{0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 1};

        rst = 1'b1;
        drive(0, 8'h00, 0, 0, 0, 1);
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", in_ready0, 1'b1);
        chk("rst_out_valid", out_valid0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_parity", out_parity0, 1'b0);
        chk("rst_err", out_err0, 1'b0);
        chk("rst_count", err_count0, 8'd0);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].m, tbl[i].p, tbl[i].r);
            cycle();
            chk($sformatf("tbl%0d_valid", i), out_valid0, tbl[i].e_v);
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d_par0", i), out_parity0, tbl[i].e_p0);
                chk($sformatf("tbl%0d_par1", i), out_parity1, tbl[i].e_p1);
                chk($sformatf("tbl%0d_err0", i), out_err0, tbl[i].e_e0);
            end
            chk($sformatf("tbl%0d_cnt0", i), err_count0, tbl[i].e_c0);
        end

        // Reset mid-frame: two beats discarded, next frame excludes them
        drive(1, 8'h01, 0, 0, 0, 1); cycle();
        drive(1, 8'h00, 0, 0, 0, 1); cycle();
        chk("midrst_busy_before", busy0, 1'b1);
        rst = 1'b1;
        drive(0, 8'h00, 0, 0, 0, 1); cycle();
        rst = 1'b0;
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_valid", out_valid0, 1'b0);
        chk("midrst_count", err_count0, 8'd0);
        drive(1, 8'h04, 1, 0, 0, 1); cycle();
        chk("midrst_par0", out_parity0, 1'b1);
        chk("midrst_par1", out_parity1, 1'b0);
        drive(0, 8'h00, 0, 0, 0, 1); cycle();

        // Saturation on the CNT_W=2 instance: five back-to-back erroring frames
        drive(1, 8'h00, 1, 1, 0, 1); cycle();
        chk("sat_start", err_count1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) drive(0, 8'h00, 0, 0, 0, 1);
            cycle();
            chk($sformatf("sat_cnt%0d", i), err_count1, sat_exp[i]);
        end

        // Randomized traffic against the model
        m_last_acc = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!(in_valid && !m_last_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
                in_par   = 1'($urandom);
            end
            mode      = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
